// File: rtl/loopback_link_ctrl.sv
// loopback_link_ctrl: HPIO TX->RX loopback bring-up sequencer and +1 counter pattern checker
module loopback_link_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 20,
    parameter int ALIGN_CNT   = 16,
    parameter int LOSS_CNT    = 4,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_pll_locked,
    input  logic             rx_pll_locked,
    input  logic             tx_rst_seq_done,
    input  logic             rx_rst_seq_done,
    input  logic [4:0]       dly_rdy,
    input  logic [4:0]       vtc_rdy,
    input  logic [3:0]       fifo_empty,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_valid,
    output logic             en_vtc,
    output logic             fifo_rd_en,
    output logic             source_rst,
    output logic             link_up,
    output logic             bringup_fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       state
);
    typedef enum logic [2:0] {
        IDLE, WAIT_SEQ, WAIT_DLY, EN_VTC, WAIT_VTC, RELEASE, ALIGN, CHECK
    } st_t;
    localparam int RUN_W = $clog2(ALIGN_CNT + LOSS_CNT + 1);
    st_t st, nxt;
    logic [SYNC_STAGES-1:0][13:0] sync;
    logic [13:0]          s;
    logic [TIMEOUT_W-1:0] tmo;
    logic [RUN_W-1:0]     run;
    logic [7:0]           prev;
    logic                 have_prev, locked, lost, tmo_st, tmo_fail, smp, good;
    assign s          = sync[SYNC_STAGES-1];
    assign locked     = s[13] & s[12];
    assign smp        = rx_data_valid & (st == ALIGN || st == CHECK);
    assign good       = have_prev & (rx_data == 8'(prev + 8'd1));
    assign lost       = (st >= WAIT_DLY) & ~locked;
    assign tmo_st     = st == WAIT_SEQ || st == WAIT_DLY || st == WAIT_VTC || st == RELEASE;
    assign fifo_rd_en = (st >= RELEASE) & ~|fifo_empty;
    assign state      = st;
    // status synchronizers: every async status bit shifts through SYNC_STAGES flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= '0;
        else      sync <= {sync[SYNC_STAGES-2:0], {tx_pll_locked, rx_pll_locked, tx_rst_seq_done, rx_rst_seq_done, dly_rdy, vtc_rdy}};
    end
    // next state: advance first, then timeout only if no advance, then loss of lock overrides all
    always_comb begin
        nxt      = st;
        tmo_fail = 1'b0;
        case (st)
            IDLE:     nxt = WAIT_SEQ;
            WAIT_SEQ: nxt = (locked & s[11] & s[10]) ? WAIT_DLY : st;
            WAIT_DLY: nxt = (&s[9:5]) ? EN_VTC : st;
            EN_VTC:   nxt = WAIT_VTC;
            WAIT_VTC: nxt = (&s[4:0]) ? RELEASE : st;
            RELEASE:  nxt = ~|fifo_empty ? ALIGN : st;
            ALIGN:    nxt = (smp & good & (run == RUN_W'(ALIGN_CNT - 1))) ? CHECK : st;
            CHECK:    nxt = (smp & ~good & (run == RUN_W'(LOSS_CNT - 1))) ? ALIGN : st;
            default:  nxt = IDLE;
        endcase
        if (tmo_st && nxt == st && &tmo && !lost) begin
            nxt      = IDLE;
            tmo_fail = 1'b1;
        end
        if (lost) nxt = IDLE;
    end
    // state, timeout, run counter and registered outputs derived from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st           <= IDLE;
            tmo          <= '0;
            run          <= '0;
            en_vtc       <= 1'b0;
            source_rst   <= 1'b1;
            link_up      <= 1'b0;
            bringup_fail <= 1'b0;
        end else begin
            st           <= nxt;
            tmo          <= (nxt != st) ? '0 : tmo_st ? tmo + 1'b1 : tmo;
            run          <= (nxt != st) ? '0 : !smp ? run : (st == ALIGN) ? (good ? run + 1'b1 : '0) : (good ? '0 : run + 1'b1);
            en_vtc       <= nxt >= EN_VTC;
            source_rst   <= nxt < RELEASE;
            link_up      <= nxt == CHECK;
            bringup_fail <= bringup_fail | tmo_fail;
        end
    end
    // sample tracking: prev reloads on every valid sample; first sample after entering ALIGN only loads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev      <= '0;
            have_prev <= 1'b0;
        end else begin
            prev      <= smp ? rx_data : prev;
            have_prev <= ((nxt == ALIGN && st != ALIGN) || nxt < ALIGN) ? 1'b0 : (smp ? 1'b1 : have_prev);
        end
    end
    // saturating error counter for bad samples seen while in CHECK
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   err_cnt <= '0;
        else if (st == CHECK && smp && !good && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_loopback_link_ctrl.sv
// tb_loopback_link_ctrl: table-driven scoreboard bench for the loopback bring-up controller
module tb_loopback_link_ctrl;
    localparam int TW = 6;
    logic        clk = 1'b0, rst = 1'b1;
    logic        tx_pll_locked = 0, rx_pll_locked = 0, tx_rst_seq_done = 0, rx_rst_seq_done = 0;
    logic [4:0]  dly_rdy = '0, vtc_rdy = '0;
    logic [3:0]  fifo_empty = 4'hF;
    logic [7:0]  rx_data = '0;
    logic        rx_data_valid = 1'b0;
    logic        en_vtc, fifo_rd_en, source_rst, link_up, bringup_fail;
    logic [15:0] err_cnt;
    logic [2:0]  state;
    int checks = 0, passes = 0;

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic [2:0]  st;
        logic        lu;
        logic [15:0] ec;
    } vec_t;
    vec_t vecs[$];
    vec_t sb[$];

    loopback_link_ctrl #(.SYNC_STAGES(2), .TIMEOUT_W(TW), .ALIGN_CNT(16), .LOSS_CNT(4), .ERR_W(16)) dut (
        .clk(clk), .rst(rst),
        .tx_pll_locked(tx_pll_locked), .rx_pll_locked(rx_pll_locked),
        .tx_rst_seq_done(tx_rst_seq_done), .rx_rst_seq_done(rx_rst_seq_done),
        .dly_rdy(dly_rdy), .vtc_rdy(vtc_rdy), .fifo_empty(fifo_empty),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .en_vtc(en_vtc), .fifo_rd_en(fifo_rd_en), .source_rst(source_rst),
        .link_up(link_up), .bringup_fail(bringup_fail), .err_cnt(err_cnt), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(logic [2:0] s, int budget, string name);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        chk(name, state, s);
    endtask

    function automatic void add(logic [7:0] d, logic v, logic [2:0] st, logic lu, logic [15:0] ec);
        vec_t x;
        x.d = d; x.v = v; x.st = st; x.lu = lu; x.ec = ec;
        vecs.push_back(x);
    endfunction

    task automatic apply(vec_t x, int idx);
        vec_t e;
        rx_data       = x.d;
        rx_data_valid = x.v;
        sb.push_back(x);
        tick();
        e = sb.pop_front();
        chk($sformatf("vec%0d {state,link_up,err_cnt}", idx), {state, link_up, err_cnt}, {e.st, e.lu, e.ec});
    endtask

    task automatic send(logic [7:0] d);
        rx_data       = d;
        rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0;
    endtask

    initial begin
        int n;
        // locking from a counter stream, with one idle cycle that must hold the run
        for (int i = 0; i <= 16; i++) begin
            add(8'(i), 1'b1, (i == 16) ? 3'd7 : 3'd6, i == 16, 16'd0);
            if (i == 5) add(8'hAA, 1'b0, 3'd6, 1'b0, 16'd0);
        end
        // running through the 0xFF->0x00 wrap up to 0x3F
        for (int i = 17; i <= 319; i++) add(8'(i), 1'b1, 3'd7, 1'b1, 16'd0);
        // 0x55 where 0x40 belongs: two errors, link holds
        add(8'h55, 1'b1, 3'd7, 1'b1, 16'd1);
        add(8'h41, 1'b1, 3'd7, 1'b1, 16'd2);
        add(8'h42, 1'b1, 3'd7, 1'b1, 16'd2);
        add(8'h43, 1'b1, 3'd7, 1'b1, 16'd2);
        // four consecutive bad samples drop the link
        for (int k = 0; k < 4; k++) add(8'h43, 1'b1, (k == 3) ? 3'd6 : 3'd7, k != 3, 16'(3 + k));
        // realign: first sample loads, a bad one restarts the run, then 16 good ones
        add(8'h10, 1'b1, 3'd6, 1'b0, 16'd6);
        add(8'h11, 1'b1, 3'd6, 1'b0, 16'd6);
        add(8'h12, 1'b1, 3'd6, 1'b0, 16'd6);
        add(8'h99, 1'b1, 3'd6, 1'b0, 16'd6);
        for (int j = 0; j < 16; j++) add(8'(8'h9A + j), 1'b1, (j == 15) ? 3'd7 : 3'd6, j == 15, 16'd6);
        add(8'hAA, 1'b1, 3'd7, 1'b1, 16'd6);

        #2 rst = 1'b0;
        #10;
        chk("reset state", state, 3'd0);
        chk("reset en_vtc", en_vtc, 1'b0);
        chk("reset fifo_rd_en", fifo_rd_en, 1'b0);
        chk("reset source_rst", source_rst, 1'b1);
        chk("reset link_up", link_up, 1'b0);
        chk("reset bringup_fail", bringup_fail, 1'b0);
        chk("reset err_cnt", err_cnt, 16'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("idle to wait_seq", state, 3'd1);
        tx_pll_locked = 1; rx_pll_locked = 1; tx_rst_seq_done = 1; rx_rst_seq_done = 1;
        wait_state(3'd2, 10, "reach WAIT_DLY");
        chk("en_vtc low in WAIT_DLY", en_vtc, 1'b0);
        dly_rdy = 5'h1F;
        wait_state(3'd3, 10, "reach EN_VTC");
        chk("en_vtc high in EN_VTC", en_vtc, 1'b1);
        tick();
        chk("EN_VTC to WAIT_VTC", state, 3'd4);
        vtc_rdy = 5'h1F;
        wait_state(3'd5, 10, "reach RELEASE");
        chk("source_rst low in RELEASE", source_rst, 1'b0);
        chk("fifo_rd_en low with empty fifos", fifo_rd_en, 1'b0);
        fifo_empty = 4'h0;
        #1;
        chk("fifo_rd_en with fifos filled", fifo_rd_en, 1'b1);
        tick();
        chk("RELEASE to ALIGN", state, 3'd6);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
        rx_data_valid = 1'b0;

        fifo_empty = 4'b0100;
        #1;
        chk("fifo_rd_en blocked by one empty fifo", fifo_rd_en, 1'b0);
        fifo_empty = 4'h0;

        rx_pll_locked = 0;
        wait_state(3'd0, 3, "lock loss to IDLE within 3 cycles");
        chk("lock loss en_vtc", en_vtc, 1'b0);
        chk("lock loss link_up", link_up, 1'b0);
        chk("lock loss source_rst", source_rst, 1'b1);
        chk("lock loss err_cnt retained", err_cnt, 16'd6);

        rx_pll_locked = 1;
        vtc_rdy = 5'b11110;
        wait_state(3'd4, 20, "reach WAIT_VTC before timeout");
        n = 0;
        while (!bringup_fail && n < 200) begin
            tick();
            n++;
        end
        chk("timeout cycles in WAIT_VTC", n, 2 ** TW);
        chk("timeout state", state, 3'd0);
        chk("timeout source_rst", source_rst, 1'b1);
        chk("timeout en_vtc", en_vtc, 1'b0);
        tick();
        tick();
        chk("bringup_fail sticky", bringup_fail, 1'b1);

        vtc_rdy = 5'h1F;
        wait_state(3'd6, 20, "re-reach ALIGN");
        for (int i = 0; i <= 16; i++) send(8'(8'hF0 + i));
        chk("relock CHECK", state, 3'd7);
        chk("relock link_up", link_up, 1'b1);
        chk("relock err_cnt retained", err_cnt, 16'd6);

        #2 rst = 1'b0;
        #1;
        chk("async reset state", state, 3'd0);
        chk("async reset link_up", link_up, 1'b0);
        chk("async reset en_vtc", en_vtc, 1'b0);
        chk("async reset source_rst", source_rst, 1'b1);
        chk("async reset bringup_fail", bringup_fail, 1'b0);
        chk("async reset err_cnt", err_cnt, 16'd0);
        chk("async reset fifo_rd_en", fifo_rd_en, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
